inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
Instruction-side producer for the RV64 decode path. It fetches 32-bit instruction words from instruction memory through a single-outstanding req/ack handshake and buffers them with their PCs in a small FIFO. It presents them to the control unit and datapath through a valid/ready interface. It also accepts PC redirects from branch/jump resolution (JAL, JALR, taken branches) and flushes stale words.

Parameters:
XLEN, 64, width of PC and memory address
RESET_PC, 64'h0, fetch address after reset (bits [1:0] must be 0)
FIFO_DEPTH, 4, instruction buffer entries; power of 2, minimum 2

Ports:
in_clk  input  1  clock, all state updates on rising edge
in_rst_n  input  1  synchronous reset, active-low
in_redirect  input  1  one-cycle pulse: flush and restart fetch at in_redirect_pc
in_redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored, treated as 0
out_mem_req  output  1  instruction memory request
out_mem_addr  output  XLEN  request address, word aligned
in_mem_ack  input  1  memory accepted request; in_mem_rdata valid this cycle
in_mem_rdata  input  32  fetched instruction word
out_inst  output  32  instruction to decode
out_inst_pc  output  XLEN  PC of out_inst
out_inst_valid  output  1  out_inst/out_inst_pc valid
in_inst_ready  input  1  consumer takes the word when valid&&ready

Behaviour:
- Reset (in_rst_n=0 at an edge):
  - out_mem_req=0, out_mem_addr=RESET_PC, fetch PC=RESET_PC.
  - FIFO empty, out_inst_valid=0, out_inst=32'h00000013 (NOP), out_inst_pc=0, state IDLE.
  - Reset overrides redirect and ack in the same cycle.
  - Reset mid-handshake abandons the request; an ack arriving after reset is ignored while state is IDLE.
- States: IDLE, FETCH, DRAIN.
  - IDLE: out_mem_req=0. Go to FETCH when credit available, credit = (FIFO count < FIFO_DEPTH).
    - First out_mem_req=1 in the cycle after reset deasserts.
  - FETCH: out_mem_req=1, out_mem_addr=fetch PC, both held stable until in_mem_ack=1.
    - On ack: push {fetch PC, in_mem_rdata}; fetch PC += 4 (mod 2^XLEN, wraps to 0).
    - After ack: stay in FETCH with the new address if credit remains after the push (back-to-back requests, one per cycle with a 0-wait memory); otherwise go to IDLE.
  - DRAIN: entered when in_redirect=1 during FETCH without a same-cycle ack.
    - out_mem_req stays 1 and out_mem_addr stays at the old address; the handshake is never withdrawn.
    - On ack: discard data, go to FETCH at the redirected PC.
    - A further redirect in DRAIN only updates the target PC.
- Redirect, effective at the edge where in_redirect=1:
  - FIFO flushed (count=0); out_inst_valid=0 next cycle.
  - Fetch PC = {in_redirect_pc[XLEN-1:2],2'b00}.
  - Redirect with same-cycle ack: the ack data is discarded, no DRAIN; FETCH at the new PC next cycle.
  - A consumer handshake in the redirect cycle still counts as consumed.
- FIFO:
  - Head drives out_inst/out_inst_pc; out_inst_valid = (count != 0). When empty, out_inst=NOP.
  - Pointers wrap mod FIFO_DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible by the credit rule; only one request is outstanding at a time.
- Latency without bypass: ack at cycle N gives out_inst_valid=1 at N+1.

Optional Feature:
INST_FETCH_BYPASS_EN
- Defined: when the FIFO is empty, state is FETCH, in_mem_ack=1 and no redirect, the word goes out combinationally the same cycle: out_inst=in_mem_rdata, out_inst_pc=fetch PC, out_inst_valid=1.
  - If in_inst_ready=1 that cycle, the word is not pushed; otherwise it is pushed normally.
- Undefined: no combinational path from memory to outputs; one-cycle minimum latency.

Test Plan:
- Reset release, RESET_PC=0x1000, 0-wait memory returning 0x00500093, ready=1 -> requests at 0x1000, 0x1004, 0x1008 on consecutive cycles; out_inst_pc sequence 0x1000, 0x1004, ...; out_inst=0x00500093.
- ready=0, DEPTH=4, 0-wait memory -> exactly 4 acks, then out_mem_req=0, count=4. Raise ready for 1 cycle -> one pop, one new request at 0x1010.
- Memory ack delayed 3 cycles -> out_mem_addr stable across all 3 cycles; a single push on ack.
- Redirect to 0x2002 while a request to 0x1008 is pending -> DRAIN; req held at 0x1008 until ack; that data is never output; next request at 0x2000; first out_inst_pc=0x2000.
- Redirect to 0x3000 in the same cycle as an ack -> ack data dropped, FIFO empty; next request at 0x3000.
- Fetch PC 0xFFFFFFFF_FFFFFFFC with ack -> next address 0x0. With the macro defined: empty FIFO, ack with ready=1 -> valid and data in the same cycle, FIFO count stays 0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - single-outstanding instruction fetch with PC/word FIFO and redirect drain
// Optional same-cycle memory-to-decode bypass when the FIFO is empty: define INST_FETCH_BYPASS_EN.
module inst_fetch_unit #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            in_clk,
  input  logic            in_rst_n,
  input  logic            in_redirect,
  input  logic [XLEN-1:0] in_redirect_pc,
  output logic            out_mem_req,
  output logic [XLEN-1:0] out_mem_addr,
  input  logic            in_mem_ack,
  input  logic [31:0]     in_mem_rdata,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_inst_pc,
  output logic            out_inst_valid,
  input  logic            in_inst_ready
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic [AW:0]     count_q, count_d, count_after;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [31:0]     inst_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
  logic            push, pop, fifo_empty, bypass;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_lsbs;

  assign redirect_target      = {in_redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^in_redirect_pc[1:0];
  assign fifo_empty           = (count_q == '0);
  assign pop                  = !fifo_empty && in_inst_ready;

`ifdef INST_FETCH_BYPASS_EN
  assign bypass = fifo_empty && (state_q == FETCH) && in_mem_ack && !in_redirect;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    push         = 1'b0;
    out_mem_req  = 1'b0;
    out_mem_addr = fetch_pc_q;
    count_after  = count_q;
    case (state_q)
      IDLE: begin
        if (in_redirect) begin
          fetch_pc_d = redirect_target;
          state_d    = FETCH;
        end else if (count_q < DEPTH_CNT) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        out_mem_req = 1'b1;
        if (in_redirect) begin
          fetch_pc_d = redirect_target;
          if (!in_mem_ack) begin
            drain_addr_d = fetch_pc_q;
            state_d      = DRAIN;
          end
        end else if (in_mem_ack) begin
          // A bypassed word that the consumer takes immediately never occupies a slot.
          push        = !(bypass && in_inst_ready);
          fetch_pc_d  = fetch_pc_q + XLEN'(4);
          count_after = count_q + (AW+1)'(push) - (AW+1)'(pop);
          if (count_after >= DEPTH_CNT) state_d = IDLE;
        end
      end
      DRAIN: begin
        // Request stays up at the stale address until memory completes it.
        out_mem_req  = 1'b1;
        out_mem_addr = drain_addr_q;
        if (in_redirect) fetch_pc_d = redirect_target;
        if (in_mem_ack)  state_d    = FETCH;
      end
      default: state_d = IDLE;
    endcase
    count_d = in_redirect ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      count_q      <= count_d;
      if (in_redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= in_mem_rdata;
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  always_comb begin
    out_inst_valid = !fifo_empty || bypass;
    out_inst       = NOP;
    out_inst_pc    = '0;
    if (!fifo_empty) begin
      out_inst    = inst_mem[rd_ptr_q];
      out_inst_pc = pc_mem[rd_ptr_q];
    end else if (bypass) begin
      out_inst    = in_mem_rdata;
      out_inst_pc = fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized bench for inst_fetch_unit against a handshake-level queue model
module tb_inst_fetch_unit;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h1000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef INST_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        in_clk = 1'b0;
  logic        in_rst_n, in_redirect, in_mem_ack, in_inst_ready;
  logic [63:0] in_redirect_pc;
  logic [31:0] in_mem_rdata;
  logic        out_mem_req, out_inst_valid;
  logic [63:0] out_mem_addr, out_inst_pc;
  logic [31:0] out_inst;

  inst_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_redirect(in_redirect),
    .in_redirect_pc(in_redirect_pc), .out_mem_req(out_mem_req), .out_mem_addr(out_mem_addr),
    .in_mem_ack(in_mem_ack), .in_mem_rdata(in_mem_rdata), .out_inst(out_inst),
    .out_inst_pc(out_inst_pc), .out_inst_valid(out_inst_valid), .in_inst_ready(in_inst_ready)
  );

  always #5 in_clk = ~in_clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: queue of delivered-but-unconsumed words plus the one outstanding request.
  typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;
  ent_t        q[$];
  logic [63:0] m_pc, m_req_addr;
  bit          m_active, m_discard, m_init = 0;

  task automatic model_step(input bit rst, input bit redir, input logic [63:0] rpc,
                            input bit ack, input logic [31:0] rdata, input bit ready);
    bit completing, bypassed, continuing;
    int was_size;
    if (rst) begin
      q.delete(); m_pc = RESET_PC; m_req_addr = RESET_PC;
      m_active = 0; m_discard = 0; m_init = 1;
      return;
    end
    completing = m_active && ack;
    continuing = m_active && !ack;
    was_size   = q.size();
    bypassed   = BYP && was_size == 0 && m_active && !m_discard && ack && !redir && ready;
    if (was_size != 0 && ready) void'(q.pop_front());
    if (redir) begin
      q.delete();
      m_pc = {rpc[63:2], 2'b00};
    end else if (completing && !m_discard) begin
      if (!bypassed) q.push_back('{pc: m_req_addr, inst: rdata});
      m_pc = m_req_addr + 64'd4;
    end
    if (completing) m_discard = 0;
    else if (redir && m_active) m_discard = 1;
    if (!continuing) begin
      m_active   = completing ? (q.size() < DEPTH) : ((was_size < DEPTH) || redir);
      m_req_addr = m_pc;
    end
  endtask

  task automatic cycle(input bit rst, input bit redir, input logic [63:0] rpc,
                       input bit ack, input logic [31:0] rdata, input bit ready);
    bit byp_now;
    in_rst_n = !rst; in_redirect = redir; in_redirect_pc = rpc;
    in_mem_ack = ack; in_mem_rdata = rdata; in_inst_ready = ready;
    #1;
    if (m_init) begin
      byp_now = BYP && q.size() == 0 && m_active && !m_discard && ack && !redir;
      check("mem_req", out_mem_req, m_active);
      if (m_active) check("mem_addr", out_mem_addr, m_req_addr);
      check("inst_valid", out_inst_valid, (q.size() != 0) || byp_now);
      if (q.size() != 0) begin
        check("inst", out_inst, q[0].inst);
        check("inst_pc", out_inst_pc, q[0].pc);
      end else if (byp_now) begin
        check("byp_inst", out_inst, rdata);
        check("byp_pc", out_inst_pc, m_req_addr);
      end else begin
        check("inst_nop", out_inst, NOP);
        check("inst_pc_zero", out_inst_pc, 64'd0);
      end
    end
    @(posedge in_clk);
    model_step(rst, redir, rpc, ack, rdata, ready);
    @(negedge in_clk);
  endtask

  initial begin
    logic [63:0] rpc;
    bit ack, rdy;
    // Reset and 0-wait streaming from RESET_PC
    cycle(1, 0, 0, 1, 32'h00500093, 1);
    cycle(1, 1, 64'h4444, 1, 32'h00500093, 1);
    check("reset_addr", out_mem_addr, RESET_PC);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 32'h00500093, 1);
    // Consumer stalled: FIFO fills, requests stop, one pop frees one slot
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 32'h00100000 + 32'(i), 0);
    check("full_no_req", out_mem_req, 1'b0);
    cycle(0, 0, 0, 1, 32'h1111, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 32'h2222 + 32'(i), 0);
    // Drain everything, then slow memory with a redirect while pending
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 1, 64'h2002, 0, 32'hdead, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 32'hdead, 1);
    cycle(0, 0, 0, 1, 32'hdeadbeef, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 32'h0000a0b3 + 32'(i), 1);
    // Redirect coinciding with an ack
    cycle(0, 1, 64'h3000, 1, 32'hbad0bad0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 32'h3333 + 32'(i), 1);
    // Address wrap at the top of the space
    cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 32'h4444 + 32'(i), 1);
    // Randomized traffic including resets, redirects and spurious acks
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: rpc = {$urandom, $urandom};
        1: rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        default: rpc = 64'($urandom_range(0, 'hFFFF));
      endcase
      ack = out_mem_req ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) == 0);
      rdy = $urandom_range(0, 9) < 5;
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 11) == 0, rpc, ack, $urandom, rdy);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
